// File: rtl/sp_ram_bank_arb_if.sv
// sp_ram_bank_arb_if: request/response bus shared by all requester ports.
// The master drives requests; the slave (the RAM subsystem) answers.
interface sp_ram_bank_arb_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]                   req_i;
    logic [NUM_PORTS-1:0]                   gnt_o;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
    logic [NUM_PORTS-1:0]                   we_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
    logic [NUM_PORTS-1:0]                   rvalid_o;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sp_ram_bank_arb.sv
// sp_ram_bank_arb: N requester ports sharing M single-port RAM banks.
// Per-bank round-robin arbitration, one-cycle read/write response.
module sp_ram_bank_arb #(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_BANKS   = 4,
    parameter int BANK_SIZE   = 1024,
    parameter int DATA_WIDTH  = 32,
    parameter bit INTERLEAVED = 1'b1,
    parameter int ADDR_WIDTH  = $clog2(NUM_BANKS) + $clog2(BANK_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sp_ram_bank_arb_if.slave bus
);
    localparam int LB  = $clog2(NUM_BANKS);
    localparam int LR  = $clog2(BANK_SIZE);
    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int NBE = DATA_WIDTH / 8;

    if ((NUM_BANKS < 2) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_bad_banks
        $error("sp_ram_bank_arb: NUM_BANKS must be a power of two >= 2");
    end
    if ((BANK_SIZE < 1) || ((BANK_SIZE & (BANK_SIZE - 1)) != 0)) begin : g_bad_size
        $error("sp_ram_bank_arb: BANK_SIZE must be a power of two");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sp_ram_bank_arb: DATA_WIDTH must be a multiple of 8");
    end

    logic [NUM_PORTS-1:0][LB-1:0]          w_bank;
    logic [NUM_PORTS-1:0][LR-1:0]          w_row;
    logic [NUM_BANKS-1:0][PW-1:0]          r_rr_ptr;
    logic [NUM_BANKS-1:0][PW-1:0]          w_win;
    logic [NUM_BANKS-1:0]                  w_bank_act;
    logic [NUM_PORTS-1:0]                  w_gnt;
    logic [NUM_BANKS-1:0][LR-1:0]          w_b_row;
    logic [NUM_BANKS-1:0]                  w_b_we;
    logic [NUM_BANKS-1:0][NBE-1:0]         w_b_be;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  w_b_wdata;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  w_bank_out;
    logic [NUM_PORTS-1:0]                  r_rvalid;
    logic [NUM_PORTS-1:0][LB-1:0]          r_bank_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        if (INTERLEAVED) begin : g_il
            assign w_bank[p] = bus.addr_i[p][LB-1:0];
            assign w_row[p]  = bus.addr_i[p][ADDR_WIDTH-1:LB];
        end else begin : g_ct
            assign w_bank[p] = bus.addr_i[p][ADDR_WIDTH-1:LR];
            assign w_row[p]  = bus.addr_i[p][LR-1:0];
        end
    end

    // Per bank: first requesting port at or after the pointer wins
    always_comb begin
        int w_idx;
        w_idx      = 0;
        w_win      = '0;
        w_bank_act = '0;
        w_gnt      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                w_idx = int'(r_rr_ptr[b]) + k;
                if (w_idx >= NUM_PORTS) begin
                    w_idx = w_idx - NUM_PORTS;
                end
                if (!w_bank_act[b] && bus.req_i[w_idx] &&
                    (int'(w_bank[w_idx]) == b)) begin
                    w_bank_act[b] = 1'b1;
                    w_win[b]      = PW'(w_idx);
                    w_gnt[w_idx]  = 1'b1;
                end
            end
        end
        if (rst_i) begin
            w_bank_act = '0;
            w_gnt      = '0;
        end
    end

    assign bus.gnt_o = w_gnt;

    // Move each granting bank's pointer just past its winner
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_act[b]) begin
                    r_rr_ptr[b] <= (w_win[b] == PW'(NUM_PORTS - 1)) ?
                                   '0 : w_win[b] + 1'b1;
                end
            end
        end
    end

    // Steer the winning port's access fields onto each bank
    always_comb begin
        w_b_row   = '0;
        w_b_we    = '0;
        w_b_be    = '0;
        w_b_wdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_b_row[b]   = w_row[w_win[b]];
            w_b_we[b]    = bus.we_i[w_win[b]];
            w_b_be[b]    = bus.be_i[w_win[b]];
            w_b_wdata[b] = bus.wdata_i[w_win[b]];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [BANK_SIZE];
        logic [DATA_WIDTH-1:0] r_rdata;

        // Byte-masked write into this bank; storage is never cleared
        always_ff @(posedge clk_i) begin
            if (w_bank_act[b] && w_b_we[b]) begin
                for (int j = 0; j < NBE; j++) begin
                    if (w_b_be[b][j]) begin
                        r_mem[w_b_row[b]][8*j +: 8] <= w_b_wdata[b][8*j +: 8];
                    end
                end
            end
        end

        // Capture the addressed word on a granted read
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_rdata <= '0;
            end else if (w_bank_act[b] && !w_b_we[b]) begin
                r_rdata <= r_mem[w_b_row[b]];
            end
        end

        assign w_bank_out[b] = r_rdata;
    end

    // Response stage: valid one cycle after grant, remember answering bank
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_bank_q <= '0;
        end else begin
            r_rvalid <= bus.req_i & w_gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt[p]) begin
                    r_bank_q[p] <= w_bank[p];
                end
            end
        end
    end

    // Route each port's answering bank; reset drops in-flight responses
    always_comb begin
        bus.rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.rdata_o[p] = rst_i ? '0 : w_bank_out[r_bank_q[p]];
        end
    end

    assign bus.rvalid_o = rst_i ? '0 : r_rvalid;
endmodule

// File: tb/tb_sp_ram_bank_arb.sv
// tb_sp_ram_bank_arb: directed and random checks of sp_ram_bank_arb.
// Instance 0 is word-interleaved, instance 1 is contiguous.
module tb_sp_ram_bank_arb;
    localparam int NP  = 2;
    localparam int NB  = 4;
    localparam int BS  = 1024;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NBE = DW / 8;
    localparam int TOT = NB * BS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]          t_req  [2];
    logic [NP-1:0][AW-1:0]  t_addr [2];
    logic [NP-1:0]          t_we   [2];
    logic [NP-1:0][NBE-1:0] t_be   [2];
    logic [NP-1:0][DW-1:0]  t_wd   [2];
    logic [NP-1:0]          o_gnt  [2];
    logic [NP-1:0]          o_rv   [2];
    logic [NP-1:0][DW-1:0]  o_rd   [2];

    sp_ram_bank_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_i ();
    sp_ram_bank_arb_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_c ();

    assign bus_i.req_i   = t_req[0];
    assign bus_i.addr_i  = t_addr[0];
    assign bus_i.we_i    = t_we[0];
    assign bus_i.be_i    = t_be[0];
    assign bus_i.wdata_i = t_wd[0];
    assign bus_c.req_i   = t_req[1];
    assign bus_c.addr_i  = t_addr[1];
    assign bus_c.we_i    = t_we[1];
    assign bus_c.be_i    = t_be[1];
    assign bus_c.wdata_i = t_wd[1];
    assign o_gnt[0] = bus_i.gnt_o;
    assign o_rv[0]  = bus_i.rvalid_o;
    assign o_rd[0]  = bus_i.rdata_o;
    assign o_gnt[1] = bus_c.gnt_o;
    assign o_rv[1]  = bus_c.rvalid_o;
    assign o_rd[1]  = bus_c.rdata_o;

    sp_ram_bank_arb #(
        .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_SIZE(BS),
        .DATA_WIDTH(DW), .INTERLEAVED(1'b1)
    ) dut_i (
        .clk_i(clk), .rst_i(rst), .bus(bus_i)
    );

    sp_ram_bank_arb #(
        .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_SIZE(BS),
        .DATA_WIDTH(DW), .INTERLEAVED(1'b0)
    ) dut_c (
        .clk_i(clk), .rst_i(rst), .bus(bus_c)
    );

    // Reference model: flat word memory per instance, pointer per bank
    int            m_ptr [2][NB];
    logic [DW-1:0] m_mem [2][TOT];
    bit            m_vld [2][TOT];
    logic [NP-1:0] e_rv  [2];
    logic [DW-1:0] e_rd  [2][NP];
    bit            e_ok  [2][NP];

    int n_cmp = 0;
    int n_err = 0;

    function automatic int bank_of(int d, int a);
        return (d == 0) ? (a % NB) : (a / BS);
    endfunction

    function automatic logic [NP-1:0] model_gnt(int d);
        logic [NP-1:0] g;
        bit taken;
        int p;
        g = '0;
        if (rst) return g;
        for (int b = 0; b < NB; b++) begin
            taken = 0;
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr[d][b] + k) % NP;
                if (!taken && t_req[d][p] &&
                    bank_of(d, int'(t_addr[d][p])) == b) begin
                    g[p]  = 1'b1;
                    taken = 1;
                end
            end
        end
        return g;
    endfunction

    task automatic model_clock(int d);
        logic [NP-1:0] g;
        int a;
        g = model_gnt(d);
        if (rst) begin
            for (int b = 0; b < NB; b++) m_ptr[d][b] = 0;
            e_rv[d] = '0;
            for (int p = 0; p < NP; p++) begin
                e_rd[d][p] = '0;
                e_ok[d][p] = 0;
            end
        end else begin
            e_rv[d] = g;
            for (int p = 0; p < NP; p++) begin
                e_ok[d][p] = 0;
                if (g[p]) begin
                    a = int'(t_addr[d][p]);
                    m_ptr[d][bank_of(d, a)] = (p + 1) % NP;
                    if (t_we[d][p]) begin
                        for (int j = 0; j < NBE; j++)
                            if (t_be[d][p][j])
                                m_mem[d][a][8*j +: 8] = t_wd[d][p][8*j +: 8];
                        if (t_be[d][p] == '1) m_vld[d][a] = 1;
                    end else begin
                        e_rd[d][p] = m_mem[d][a];
                        e_ok[d][p] = m_vld[d][a];
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_clock(0);
        model_clock(1);
        @(negedge clk);
    endtask

    task automatic set_port(int d, int p, bit rq, int a, bit we,
                            logic [NBE-1:0] be, logic [DW-1:0] wd);
        t_req[d][p]  = rq;
        t_addr[d][p] = AW'(a);
        t_we[d][p]   = we;
        t_be[d][p]   = be;
        t_wd[d][p]   = wd;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) t_req[d] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                set_port(0, 0, 1, 5, 0, '1, '0);
                set_port(1, 1, 1, 6, 1, '1, 32'h1234_5678);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_gnt[d] !== '0) begin
                    n_err++;
                    $display("FAIL reset_gnt d%0d got=%b exp=00", d, o_gnt[d]);
                end
                n_cmp++;
                if (o_rv[d] !== '0) begin
                    n_err++;
                    $display("FAIL reset_rvalid d%0d got=%b exp=00", d, o_rv[d]);
                end
                n_cmp++;
                if (o_rd[d] !== '0) begin
                    n_err++;
                    $display("FAIL reset_rdata d%0d got=%h exp=0", d, o_rd[d]);
                end
            end
            step();
        end
        rst = 1'b0;
        idle_all();
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (o_gnt[d] !== '0 || o_rv[d] !== '0) begin
                    n_err++;
                    $display("FAIL idle_after_reset d%0d gnt=%b rv=%b exp=00/00",
                             d, o_gnt[d], o_rv[d]);
                end
            end
            step();
        end
    endtask

    task automatic test_single_rw();
        logic [NP-1:0] eg [5];
        logic [NP-1:0] erv [5];
        eg  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        erv = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        for (int c = 0; c < 5; c++) begin
            idle_all();
            case (c)
                0: set_port(0, 0, 1, 5, 1, 4'hF, 32'hDEAD_BEEF);
                1: set_port(0, 0, 1, 5, 0, 4'hF, 32'h0);
                2: set_port(0, 0, 1, 5, 1, 4'b0010, 32'h0000_5500);
                3: set_port(0, 0, 1, 5, 0, 4'hF, 32'h0);
                default: ;
            endcase
            #1;
            n_cmp++;
            if (o_gnt[0] !== eg[c]) begin
                n_err++;
                $display("FAIL single_gnt c%0d got=%b exp=%b", c, o_gnt[0], eg[c]);
            end
            n_cmp++;
            if (o_rv[0] !== erv[c]) begin
                n_err++;
                $display("FAIL single_rvalid c%0d got=%b exp=%b", c, o_rv[0], erv[c]);
            end
            if (c == 2) begin
                n_cmp++;
                if (o_rd[0][0] !== 32'hDEAD_BEEF) begin
                    n_err++;
                    $display("FAIL single_read1 got=%h exp=deadbeef", o_rd[0][0]);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (o_rd[0][0] !== 32'hDEAD_55EF) begin
                    n_err++;
                    $display("FAIL single_read2 got=%h exp=dead55ef", o_rd[0][0]);
                end
            end
            step();
        end
    endtask

    task automatic test_parallel();
        idle_all();
        set_port(0, 0, 1, 'h004, 1, '1, 32'h1111_1111);
        set_port(0, 1, 1, 'h001, 1, '1, 32'h2222_2222);
        #1;
        step();
        set_port(0, 0, 1, 'h004, 0, '1, '0);
        set_port(0, 1, 1, 'h001, 0, '1, '0);
        #1;
        n_cmp++;
        if (o_gnt[0] !== 2'b11) begin
            n_err++;
            $display("FAIL parallel_gnt got=%b exp=11", o_gnt[0]);
        end
        step();
        idle_all();
        #1;
        n_cmp++;
        if (o_rv[0] !== 2'b11 || o_rd[0][0] !== 32'h1111_1111 ||
            o_rd[0][1] !== 32'h2222_2222) begin
            n_err++;
            $display("FAIL parallel_read rv=%b d0=%h d1=%h exp=11/11111111/22222222",
                     o_rv[0], o_rd[0][0], o_rd[0][1]);
        end
        step();
    endtask

    task automatic test_contention();
        logic [NP-1:0] seq [4];
        int w;
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
        idle_all();
        set_port(0, 1, 1, 'h002, 1, '1, 32'hA0A0_A0A0);
        #1;
        step();
        set_port(0, 1, 1, 'h006, 1, '1, 32'hB6B6_B6B6);
        #1;
        step();
        set_port(0, 0, 1, 'h002, 0, '1, '0);
        set_port(0, 1, 1, 'h006, 0, '1, '0);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) idle_all();
            #1;
            if (c < 4) begin
                n_cmp++;
                if (o_gnt[0] !== seq[c]) begin
                    n_err++;
                    $display("FAIL contention_gnt c%0d got=%b exp=%b",
                             c, o_gnt[0], seq[c]);
                end
            end
            if (c > 0) begin
                w = (seq[c-1] == 2'b01) ? 0 : 1;
                n_cmp++;
                if (o_rv[0] !== seq[c-1] ||
                    o_rd[0][w] !== ((w == 0) ? 32'hA0A0_A0A0 : 32'hB6B6_B6B6)) begin
                    n_err++;
                    $display("FAIL contention_resp c%0d rv=%b exp=%b data=%h",
                             c, o_rv[0], seq[c-1], o_rd[0][w]);
                end
            end
            step();
        end
    endtask

    task automatic test_contiguous();
        idle_all();
        set_port(1, 0, 1, 'h400, 1, '1, 32'hC3C3_C3C3);
        #1;
        step();
        set_port(1, 0, 1, 'h7FF, 1, '1, 32'h5A5A_5A5A);
        #1;
        step();
        set_port(1, 0, 1, 'h400, 0, '1, '0);
        set_port(1, 1, 1, 'h7FF, 0, '1, '0);
        #1;
        n_cmp++;
        if (o_gnt[1] !== 2'b10) begin
            n_err++;
            $display("FAIL contig_gnt1 got=%b exp=10", o_gnt[1]);
        end
        step();
        t_req[1][1] = 1'b0;
        #1;
        n_cmp++;
        if (o_gnt[1] !== 2'b01) begin
            n_err++;
            $display("FAIL contig_gnt2 got=%b exp=01", o_gnt[1]);
        end
        n_cmp++;
        if (o_rv[1] !== 2'b10 || o_rd[1][1] !== 32'h5A5A_5A5A) begin
            n_err++;
            $display("FAIL contig_resp1 rv=%b data=%h exp=10/5a5a5a5a",
                     o_rv[1], o_rd[1][1]);
        end
        step();
        set_port(1, 0, 1, 'h000, 0, '1, '0);
        set_port(1, 1, 1, 'h400, 0, '1, '0);
        #1;
        n_cmp++;
        if (o_gnt[1] !== 2'b11) begin
            n_err++;
            $display("FAIL contig_gnt3 got=%b exp=11", o_gnt[1]);
        end
        n_cmp++;
        if (o_rv[1] !== 2'b01 || o_rd[1][0] !== 32'hC3C3_C3C3) begin
            n_err++;
            $display("FAIL contig_resp2 rv=%b data=%h exp=01/c3c3c3c3",
                     o_rv[1], o_rd[1][0]);
        end
        step();
        idle_all();
        #1;
        n_cmp++;
        if (o_rv[1] !== 2'b11 || o_rd[1][1] !== 32'hC3C3_C3C3) begin
            n_err++;
            $display("FAIL contig_resp3 rv=%b data=%h exp=11/c3c3c3c3",
                     o_rv[1], o_rd[1][1]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        idle_all();
        set_port(0, 0, 1, 'h010, 1, '1, 32'h0BAD_F00D);
        #1;
        step();
        set_port(0, 0, 1, 'h010, 0, '1, '0);
        #1;
        n_cmp++;
        if (o_gnt[0] !== 2'b01) begin
            n_err++;
            $display("FAIL midrst_gnt got=%b exp=01", o_gnt[0]);
        end
        step();
        idle_all();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (o_rv[0] !== 2'b00 || o_rd[0][0] !== '0) begin
            n_err++;
            $display("FAIL midrst_drop rv=%b data=%h exp=00/0", o_rv[0], o_rd[0][0]);
        end
        step();
        rst = 1'b0;
        #1;
        step();
        set_port(0, 0, 1, 'h010, 0, '1, '0);
        #1;
        step();
        idle_all();
        #1;
        n_cmp++;
        if (o_rv[0] !== 2'b01 || o_rd[0][0] !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL midrst_keep rv=%b data=%h exp=01/0badf00d",
                     o_rv[0], o_rd[0][0]);
        end
        step();
    endtask

    task automatic test_random();
        logic [NP-1:0] pg [2];
        logic [NP-1:0] eg;
        int a;
        pg[0] = '0;
        pg[1] = '0;
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NP; p++) begin
                    if (t_req[d][p] && !pg[d][p]) begin
                        if ($urandom_range(0, 7) == 0) t_req[d][p] = 1'b0;
                    end else begin
                        if (d == 0) a = int'($urandom_range(0, 31));
                        else a = int'($urandom_range(0, 3)) * BS +
                                 int'($urandom_range(0, 7));
                        set_port(d, p, $urandom_range(0, 9) < 7, a,
                                 1'($urandom_range(0, 1)),
                                 NBE'($urandom), DW'($urandom));
                    end
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                eg = model_gnt(d);
                pg[d] = eg;
                n_cmp++;
                if (o_gnt[d] !== eg) begin
                    n_err++;
                    $display("FAIL rand_gnt c%0d d%0d got=%b exp=%b",
                             c, d, o_gnt[d], eg);
                end
                n_cmp++;
                if (o_rv[d] !== e_rv[d]) begin
                    n_err++;
                    $display("FAIL rand_rvalid c%0d d%0d got=%b exp=%b",
                             c, d, o_rv[d], e_rv[d]);
                end
                for (int p = 0; p < NP; p++) begin
                    if (e_rv[d][p] && e_ok[d][p]) begin
                        n_cmp++;
                        if (o_rd[d][p] !== e_rd[d][p]) begin
                            n_err++;
                            $display("FAIL rand_rdata c%0d d%0d p%0d got=%h exp=%h",
                                     c, d, p, o_rd[d][p], e_rd[d][p]);
                        end
                    end
                end
            end
            step();
        end
        idle_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            t_req[d]  = '0;
            t_addr[d] = '0;
            t_we[d]   = '0;
            t_be[d]   = '0;
            t_wd[d]   = '0;
            e_rv[d]   = '0;
            for (int p = 0; p < NP; p++) begin
                e_rd[d][p] = '0;
                e_ok[d][p] = 0;
            end
        end
        @(negedge clk);
        test_reset();
        test_single_rw();
        test_parallel();
        test_contention();
        test_contiguous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
